// File: rtl/muldiv_sequencer.sv
// Iterative HI/LO unit beside the Execute ALU: shift-add multiply, restoring divide,
// MTHI/MTLO/MFHI/MFLO handling and a stall request while an operation is in flight.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] mfOut,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX
  } state_t;

  state_t             state_reg;
  logic [CW-1:0]      count_reg;
  logic [2*WIDTH-1:0] work_reg;
  logic [2*WIDTH-1:0] work_next;
  logic [WIDTH-1:0]   opnd_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               is_div_reg;
  logic               neg_main_reg;
  logic               neg_rem_reg;
  logic               dbz_reg;
  logic               busy_reg;
  logic               done_reg;

  // Request decode and operand magnitudes
  logic             is_muldiv;
  logic             is_hilo;
  logic             is_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  always_comb begin
    is_muldiv = (funct == F_MULT) || (funct == F_MULTU) ||
                (funct == F_DIV)  || (funct == F_DIVU);
    is_hilo   = is_muldiv || (funct == F_MFHI) || (funct == F_MTHI) ||
                (funct == F_MFLO) || (funct == F_MTLO);
    is_signed = (funct == F_MULT) || (funct == F_DIV);
    a_neg     = is_signed && inputA[WIDTH-1];
    b_neg     = is_signed && inputB[WIDTH-1];
    mag_a     = a_neg ? -inputA : inputA;
    mag_b     = b_neg ? -inputB : inputB;
  end

  // One iteration step. work_reg holds {upper, lower}: for multiply the partial
  // product over the shifting multiplier, for divide the remainder over the quotient.
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] rem_sub;
  logic             can_sub;

  always_comb begin
    shifted = {work_reg[2*WIDTH-1:WIDTH], work_reg[WIDTH-1]};
    can_sub = shifted >= {1'b0, opnd_reg};
    rem_sub = shifted[WIDTH-1:0] - opnd_reg;
    mul_sum = {1'b0, work_reg[2*WIDTH-1:WIDTH]} +
              (work_reg[0] ? {1'b0, opnd_reg} : {(WIDTH+1){1'b0}});
    if (is_div_reg) begin
      work_next = can_sub ? {rem_sub, work_reg[WIDTH-2:0], 1'b1}
                          : {shifted[WIDTH-1:0], work_reg[WIDTH-2:0], 1'b0};
    end else begin
      work_next = {mul_sum, work_reg[WIDTH-1:1]};
    end
  end

  // Sign correction applied at writeback
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_mag;
  logic [WIDTH-1:0]   rem_mag;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  always_comb begin
    prod_fix = neg_main_reg ? -work_reg : work_reg;
    quo_mag  = work_reg[WIDTH-1:0];
    rem_mag  = work_reg[2*WIDTH-1:WIDTH];
    if (is_div_reg) begin
      // With a zero divisor the remainder path reproduces the dividend, so hi = raw A.
      res_lo = dbz_reg ? {WIDTH{1'b1}} : (neg_main_reg ? -quo_mag : quo_mag);
      res_hi = neg_rem_reg ? -rem_mag : rem_mag;
    end else begin
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
      res_lo = prod_fix[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      count_reg    <= '0;
      work_reg     <= '0;
      opnd_reg     <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      is_div_reg   <= 1'b0;
      neg_main_reg <= 1'b0;
      neg_rem_reg  <= 1'b0;
      dbz_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      unique case (state_reg)
        S_IDLE: begin
          if (start && !flush) begin
            if (funct == F_MTHI) begin
              hi_reg <= inputA;
            end else if (funct == F_MTLO) begin
              lo_reg <= inputA;
            end else if (is_muldiv) begin
              // funct[1] separates DIV/DIVU from MULT/MULTU
              is_div_reg   <= funct[1];
              opnd_reg     <= funct[1] ? mag_b : mag_a;
              work_reg     <= {{WIDTH{1'b0}}, (funct[1] ? mag_a : mag_b)};
              neg_main_reg <= a_neg ^ b_neg;
              neg_rem_reg  <= a_neg;
              dbz_reg      <= (inputB == '0);
              count_reg    <= '0;
              busy_reg     <= 1'b1;
              state_reg    <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (flush) begin
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end else begin
            work_reg  <= work_next;
            count_reg <= count_reg + CW'(1);
            if (count_reg == CW'(WIDTH-1)) begin
              state_reg <= S_FIX;
            end
          end
        end
        S_FIX: begin
          if (!flush) begin
            hi_reg   <= res_hi;
            lo_reg   <= res_lo;
            done_reg <= 1'b1;
          end
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign hi    = hi_reg;
  assign lo    = lo_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;
  assign mfOut = (funct == F_MFHI) ? hi_reg : lo_reg;
  assign stall = start && is_hilo && (state_reg != S_IDLE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed plus randomized bench for muldiv_sequencer; results come from a plain
// arithmetic reference of MIPS HI/LO semantics.
module tb_muldiv_sequencer;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  logic        clk, rst, start, flush;
  logic [5:0]  funct;
  logic [31:0] inputA, inputB, hi, lo, mfOut;
  logic        busy, stall, done;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct(funct),
    .inputA(inputA), .inputB(inputB), .flush(flush),
    .hi(hi), .lo(lo), .mfOut(mfOut), .busy(busy), .stall(stall), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: MIPS HI/LO arithmetic computed in 64-bit integers
  task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el);
    longint sa, sb, r;
    longint unsigned ua, ub, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    eh = '0;
    el = '0;
    case (f)
      F_MULT:  begin r = sa * sb; eh = r[63:32]; el = r[31:0]; end
      F_MULTU: begin ur = ua * ub; eh = ur[63:32]; el = ur[31:0]; end
      F_DIV: begin
        if (b == 32'd0) begin el = 32'hFFFF_FFFF; eh = a; end
        else begin r = sa / sb; el = r[31:0]; r = sa % sb; eh = r[31:0]; end
      end
      F_DIVU: begin
        if (b == 32'd0) begin el = 32'hFFFF_FFFF; eh = a; end
        else begin ur = ua / ub; el = ur[31:0]; ur = ua % ub; eh = ur[31:0]; end
      end
      default: begin eh = m_hi; el = m_lo; end
    endcase
  endtask

  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    model(f, a, b, eh, el);
    start = 1'b1; funct = f; inputA = a; inputB = b;
    tick();
    start = 1'b0; funct = 6'b0;
    check("busy_after_accept", busy, 1'b1);
    for (int i = 1; i <= 32; i++) begin
      tick();
      check("busy_running", busy, 1'b1);
      check("done_while_busy", done, 1'b0);
    end
    tick();
    check("done_pulse", done, 1'b1);
    check("busy_cleared", busy, 1'b0);
    check("hi_result", hi, eh);
    check("lo_result", lo, el);
    tick();
    check("done_one_cycle", done, 1'b0);
    m_hi = eh;
    m_lo = el;
    $display("op funct=%b a=%h b=%h -> hi=%h lo=%h", f, a, b, hi, lo);
  endtask

  task automatic move_to(input logic [5:0] f, input logic [31:0] v);
    start = 1'b1; funct = f; inputA = v;
    tick();
    start = 1'b0; funct = 6'b0;
    if (f == F_MTHI) m_hi = v; else m_lo = v;
    check("mt_hi", hi, m_hi);
    check("mt_lo", lo, m_lo);
    check("mt_no_done", done, 1'b0);
    $display("move funct=%b v=%h -> hi=%h lo=%h", f, v, hi, lo);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] eh, el;
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct = 6'b0; inputA = '0; inputB = '0;
    m_hi = '0; m_lo = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_stall", stall, 1'b0);
    $display("reset released");

    // Directed arithmetic
    run_op(F_MULT,  32'hFFFF_FFFD, 32'd7);
    run_op(F_DIVU,  32'd100, 32'd7);
    run_op(F_DIV,   32'hFFFF_FFF9, 32'd2);
    run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(F_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    run_op(F_DIVU,  32'd55, 32'd0);
    run_op(F_DIV,   32'hFFFF_FFF0, 32'd0);

    // MF in idle: combinational, no stall
    start = 1'b1; funct = F_MFHI; #1;
    check("mfhi_idle", mfOut, m_hi);
    check("mfhi_nostall", stall, 1'b0);
    funct = F_MFLO; #1;
    check("mflo_idle", mfOut, m_lo);
    tick();
    start = 1'b0;
    $display("mf read hi=%h lo=%h", m_hi, m_lo);

    // Non-HI/LO funct ignored
    start = 1'b1; funct = 6'b100000; inputA = 32'hDEAD_BEEF; inputB = 32'd3; #1;
    check("other_nostall", stall, 1'b0);
    tick();
    start = 1'b0;
    check("other_busy", busy, 1'b0);
    check("other_hi", hi, m_hi);
    $display("ignored funct=100000");

    // Flush in idle discards the request
    start = 1'b1; flush = 1'b1; funct = F_MTHI; inputA = 32'hCAFE_F00D;
    tick();
    start = 1'b0; flush = 1'b0;
    check("idle_flush_hi", hi, m_hi);
    start = 1'b1; flush = 1'b1; funct = F_MULT; inputA = 32'd9; inputB = 32'd9;
    tick();
    start = 1'b0; flush = 1'b0;
    check("idle_flush_busy", busy, 1'b0);
    $display("idle flush discarded requests");

    // DIV with MFLO held from E1: stall through E33, then fresh lo visible
    model(F_DIV, 32'd1000, 32'hFFFF_FFFD, eh, el);
    start = 1'b1; funct = F_DIV; inputA = 32'd1000; inputB = 32'hFFFF_FFFD;
    tick();
    funct = F_MFLO;
    for (int k = 1; k <= 33; k++) begin
      check("stall_held_mflo", stall, 1'b1);
      tick();
    end
    check("stall_released", stall, 1'b0);
    check("mflo_new", mfOut, el);
    check("stall_done", done, 1'b1);
    tick();
    start = 1'b0;
    m_hi = eh; m_lo = el;
    $display("held mflo released lo=%h", mfOut);

    // MTHI presented mid-op stalls; hi untouched until accepted after FIX
    model(F_MULTU, 32'h0001_0003, 32'h0002_0005, eh, el);
    start = 1'b1; funct = F_MULTU; inputA = 32'h0001_0003; inputB = 32'h0002_0005;
    tick();
    funct = F_MTHI; inputA = 32'hA5A5_0001;
    for (int k = 1; k <= 33; k++) begin
      check("stall_held_mthi", stall, 1'b1);
      check("hi_unchanged", hi, m_hi);
      tick();
    end
    check("mthi_op_hi", hi, eh);
    check("mthi_stall_off", stall, 1'b0);
    tick();
    start = 1'b0;
    check("mthi_applied", hi, 32'hA5A5_0001);
    check("mthi_lo_kept", lo, el);
    m_hi = 32'hA5A5_0001; m_lo = el;
    $display("held mthi applied hi=%h", hi);

    // Flush at E10
    move_to(F_MTHI, 32'h1234_5678);
    move_to(F_MTLO, 32'h1234_5678);
    start = 1'b1; funct = F_MULT; inputA = 32'd123; inputB = 32'd456;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 9; k++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", busy, 1'b0);
    check("flush_hi", hi, 32'h1234_5678);
    check("flush_lo", lo, 32'h1234_5678);
    for (int k = 0; k < 30; k++) begin
      check("flush_no_done", done, 1'b0);
      tick();
    end
    check("flush_hi_late", hi, 32'h1234_5678);
    $display("flush at E10 hi=%h lo=%h", hi, lo);

    // Reset at E10
    start = 1'b1; funct = F_MULT; inputA = 32'd77; inputB = 32'd11;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 9; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_hi = '0; m_lo = '0;
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_hi", hi, 32'h0);
    check("rstmid_lo", lo, 32'h0);
    for (int k = 0; k < 30; k++) begin
      check("rstmid_no_done", done, 1'b0);
      tick();
    end
    $display("reset at E10 hi=%h lo=%h", hi, lo);

    // Randomized operations against the reference
    for (int n = 0; n < 16; n++) begin
      logic [5:0]  f;
      logic [31:0] a, b;
      f = F_MULT + 6'($urandom_range(0, 3));
      a = pick();
      b = pick();
      run_op(f, a, b);
      start = 1'b1; funct = F_MFHI; #1;
      check("rand_mfhi", mfOut, m_hi);
      tick();
      start = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
